// File: rtl/fib_pkg.sv
// Shared constants, state encoding and the Fibonacci term table for the
// Zeckendorf decoder.
package fib_pkg;

    localparam int WIDTH  = 8;
    localparam int NTERMS = 12;

    localparam logic [7:0] FIB_TOP  = 8'd233;
    localparam logic [7:0] FIB_NEXT = 8'd144;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Value of the term represented by code bit idx (bit0 = 1 ... bit11 = 233).
    function automatic logic [7:0] fib_term(input int idx);
        case (idx)
            0:       return 8'd1;
            1:       return 8'd2;
            2:       return 8'd3;
            3:       return 8'd5;
            4:       return 8'd8;
            5:       return 8'd13;
            6:       return 8'd21;
            7:       return 8'd34;
            8:       return 8'd55;
            9:       return 8'd89;
            10:      return 8'd144;
            11:      return 8'd233;
            default: return 8'd0;
        endcase
    endfunction

endpackage

// File: rtl/zeck_step.sv
// One greedy decomposition step: take the current term if it fits, then walk
// the Fibonacci pair one position down by subtraction.
module zeck_step (
    input  logic [7:0] rem,
    input  logic [7:0] cur,
    input  logic [7:0] prev,
    output logic       take,
    output logic [7:0] rem_next,
    output logic [7:0] cur_next,
    output logic [7:0] prev_next
);

    assign take     = (rem >= cur);
    assign rem_next = take ? (rem - cur) : rem;
    assign cur_next = prev;
    // The last step's prev is never consumed; saturate it so it cannot wrap.
    assign prev_next = (cur >= prev) ? (cur - prev) : 8'd0;

endmodule

// File: rtl/fib_zeckendorf_decoder.sv
// Sequential Zeckendorf decoder: splits an 8-bit value into non-consecutive
// Fibonacci terms over 12 RUN cycles, with valid/ready on both sides.
module fib_zeckendorf_decoder
    import fib_pkg::*;
#(
    parameter int WIDTH = fib_pkg::WIDTH
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  in_value,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [NTERMS-1:0] out_code,
    output logic [3:0]        out_nterms,
    output logic              out_is_fib
);

    if (WIDTH != 8) begin : g_width_check
        $error("fib_zeckendorf_decoder supports WIDTH=8 only");
    end

    state_t     state;
    logic [7:0] rem;
    logic [7:0] cur;
    logic [7:0] prev;
    logic [3:0] idx;

    logic       take;
    logic [7:0] rem_next;
    logic [7:0] cur_next;
    logic [7:0] prev_next;
    logic [3:0] nterms_next;

    zeck_step u_step (
        .rem       (rem),
        .cur       (cur),
        .prev      (prev),
        .take      (take),
        .rem_next  (rem_next),
        .cur_next  (cur_next),
        .prev_next (prev_next)
    );

    assign nterms_next = out_nterms + {3'd0, take};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            rem        <= '0;
            cur        <= '0;
            prev       <= '0;
            idx        <= '0;
            in_ready   <= 1'b1;
            out_valid  <= 1'b0;
            out_code   <= '0;
            out_nterms <= '0;
            out_is_fib <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        rem        <= in_value;
                        cur        <= FIB_TOP;
                        prev       <= FIB_NEXT;
                        idx        <= 4'(NTERMS - 1);
                        out_code   <= '0;
                        out_nterms <= '0;
                        out_is_fib <= 1'b0;
                        in_ready   <= 1'b0;
                        state      <= RUN;
                    end
                end
                RUN: begin
                    rem  <= rem_next;
                    cur  <= cur_next;
                    prev <= prev_next;
                    idx  <= idx - 4'd1;
                    if (take) begin
                        out_code[idx] <= 1'b1;
                        out_nterms    <= nterms_next;
                    end
                    if (idx == 4'd0) begin
                        // Greedy over the full term set always consumes the value.
                        assert (rem_next == 8'd0);
                        out_is_fib <= (nterms_next == 4'd1);
                        out_valid  <= 1'b1;
                        state      <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state    <= IDLE;
                    in_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fib_zeckendorf_decoder.sv
// Scoreboard bench for fib_zeckendorf_decoder: directed vectors, backpressure,
// reset mid-run and a full 0..255 sweep against a greedy reference.
module tb_fib_zeckendorf_decoder;
    import fib_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_value;
    logic        out_valid;
    logic        out_ready;
    logic [11:0] out_code;
    logic [3:0]  out_nterms;
    logic        out_is_fib;

    fib_zeckendorf_decoder dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_value   (in_value),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_code   (out_code),
        .out_nterms (out_nterms),
        .out_is_fib (out_is_fib)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  value;
        logic [11:0] code;
        logic [3:0]  nterms;
        logic        is_fib;
    } exp_t;

    exp_t exp_q[$];
    time  acc_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic int term_sum(input logic [11:0] code);
        int s = 0;
        for (int i = 0; i < 12; i++)
            if (code[i]) s += int'(fib_term(i));
        return s;
    endfunction

    function automatic logic [11:0] ref_code(input logic [7:0] v);
        logic [11:0] c = '0;
        int r = int'(v);
        for (int i = 11; i >= 0; i--) begin
            if (r >= int'(fib_term(i))) begin
                c[i] = 1'b1;
                r -= int'(fib_term(i));
            end
        end
        return c;
    endfunction

    function automatic logic ref_is_fib(input logic [7:0] v);
        for (int i = 0; i < 12; i++)
            if (fib_term(i) == v) return 1'b1;
        return 1'b0;
    endfunction

    // Issue one value; expected result goes to the scoreboard only if push is set.
    task automatic send(input logic [7:0] v, input logic [11:0] code,
                        input int nterms, input logic is_fib, input bit push);
        exp_t e;
        bit   ok = 0;
        e.value  = v;
        e.code   = code;
        e.nterms = 4'(nterms);
        e.is_fib = is_fib;
        if (push) exp_q.push_back(e);
        @(posedge clk); #1;
        in_valid = 1'b1;
        in_value = v;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1;
                break;
            end
        end
        if (!ok) begin
            check("accept_timeout", 0, 1);
            in_valid = 1'b0;
            if (push) exp_q.delete(exp_q.size() - 1);
            return;
        end
        @(posedge clk);
        if (push) acc_q.push_back($time);
        #1 in_valid = 1'b0;
    endtask

    task automatic drain();
        bit ok = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !out_valid) begin
                ok = 1;
                break;
            end
        end
        if (!ok) check("drain_timeout", 0, 1);
    endtask

    // Monitor: check on the first cycle of out_valid, pop on the handshake.
    bit   seen = 0;
    exp_t cur_e;
    always @(negedge clk) begin
        if (!rst_n) begin
            seen = 0;
        end else if (out_valid) begin
            if (!seen) begin
                seen = 1;
                if (exp_q.size() == 0 || acc_q.size() == 0) begin
                    check("unexpected_output", int'(out_code), -1);
                end else begin
                    cur_e = exp_q[0];
                    check("latency", int'(($time - acc_q.pop_front() - 5) / 10), 12);
                    check("code", int'(out_code), int'(cur_e.code));
                    check("nterms", int'(out_nterms), int'(cur_e.nterms));
                    check("is_fib", int'(out_is_fib), int'(cur_e.is_fib));
                    check("no_adjacent", int'(out_code & (out_code >> 1)), 0);
                    check("term_sum", term_sum(out_code), int'(cur_e.value));
                end
            end
            if (out_ready) begin
                if (exp_q.size() != 0) begin
                    check("held_code", int'(out_code), int'(exp_q[0].code));
                    exp_q.delete(0);
                end
                seen = 0;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_value  = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", int'(in_ready), 1);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_code", int'(out_code), 0);
        check("rst_nterms", int'(out_nterms), 0);
        check("rst_is_fib", int'(out_is_fib), 0);
        @(posedge clk); #1 rst_n = 1'b1;

        send(8'd100, 12'h214, 3, 1'b0, 1);
        send(8'd233, 12'h800, 1, 1'b1, 1);
        send(8'd255, 12'h841, 3, 1'b0, 1);
        send(8'd232, 12'h555, 6, 1'b0, 1);
        send(8'd0,   12'h000, 0, 1'b0, 1);
        drain();

        // Backpressure: result held, new input refused while in DONE.
        @(posedge clk); #1 out_ready = 1'b0;
        send(8'd100, 12'h214, 3, 1'b0, 1);
        ok = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_valid) begin
                ok = 1;
                break;
            end
        end
        if (!ok) check("bp_valid_timeout", 0, 1);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            in_valid = 1'b1;
            in_value = 8'd50;
            @(negedge clk);
            check("bp_valid", int'(out_valid), 1);
            check("bp_code", int'(out_code), 12'h214);
            check("bp_nterms", int'(out_nterms), 3);
            check("bp_in_ready", int'(in_ready), 0);
        end
        @(posedge clk); #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("bp_release_in_ready", int'(in_ready), 1);
        check("bp_release_valid", int'(out_valid), 0);
        send(8'd1, 12'h001, 1, 1'b1, 1);
        send(8'd2, 12'h002, 1, 1'b1, 1);
        drain();

        // Reset asserted on the 6th RUN cycle discards the value.
        send(8'd77, 12'h000, 0, 1'b0, 0);
        repeat (5) @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("midrst_in_ready", int'(in_ready), 1);
        check("midrst_out_valid", int'(out_valid), 0);
        check("midrst_code", int'(out_code), 0);
        @(posedge clk); #1 rst_n = 1'b1;
        send(8'd21, 12'h040, 1, 1'b1, 1);
        drain();

        for (int v = 0; v < 256; v++) begin
            logic [11:0] c;
            c = ref_code(8'(v));
            send(8'(v), c, $countones(c), ref_is_fib(8'(v)), 1);
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
